// File: rtl/e_muldiv.sv
// e_muldiv: execute-stage multiply/divide unit owning the HI/LO registers.
// Runs MULT/MULTU as a 32-step shift-add and DIV/DIVU as a radix-2 restoring
// divide on operand magnitudes, followed by a one-cycle sign-fix step.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
module e_muldiv #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS + 1);

    state_t           state;
    state_t           state_nx;
    op_t              op_code;
    logic [CNT_W-1:0] count;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [63:0]      acc;
    logic [31:0]      operand;     // multiplicand or divisor magnitude
    logic [31:0]      dividend;    // raw dividend, returned in HI on divide by zero
    logic             neg_res;     // negate product / quotient
    logic             neg_rem;     // negate remainder (dividend was negative)
    logic             div_zero;

    logic             is_signed;
    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             mul_last;
    logic             div_last;
    logic             mul_wr;
    logic             div_wr;
    logic             mthi_wr;
    logic             mtlo_wr;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [32:0]      mul_sum;
    logic [63:0]      mul_next;
    logic [63:0]      mul_res;
    logic [33:0]      div_trial;
    logic [63:0]      div_next;
    logic [31:0]      quo_fix;
    logic [31:0]      rem_fix;

    assign op_code   = op_t'(op);
    assign is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign is_mul    = (op_code == OP_MULT) || (op_code == OP_MULTU);
    assign is_div    = (op_code == OP_DIV)  || (op_code == OP_DIVU);
    assign mag_a     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (is_signed && b[31]) ? (~b + 32'd1) : b;

`ifdef MULDIV_FAST_MUL_EN
    assign mul_last  = 1'b1;
`else
    assign mul_last  = (count == CNT_W'(MUL_ITERS - 1));
`endif
    assign div_last  = (count == CNT_W'(DIV_ITERS - 1));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state, write strobes and the combinational stall request.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nx = state;
        start    = 1'b0;
        mul_wr   = 1'b0;
        div_wr   = 1'b0;
        mthi_wr  = 1'b0;
        mtlo_wr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !flush) begin
                    if (is_mul) begin
                        state_nx = S_MUL;
                        start    = 1'b1;
                    end else if (is_div) begin
                        state_nx = S_DIV;
                        start    = 1'b1;
                    end else if (op_code == OP_MTHI) begin
                        mthi_wr  = 1'b1;
                    end else if (op_code == OP_MTLO) begin
                        mtlo_wr  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (mul_last) begin
                    state_nx = S_IDLE;
                    mul_wr   = 1'b1;
                end
            end
            S_DIV: begin
                if (flush)         state_nx = S_IDLE;
                else if (div_last) state_nx = S_FIX;
            end
            S_FIX: begin
                state_nx = S_IDLE;
                div_wr   = !flush;
            end
            default: state_nx = S_IDLE;
        endcase
        // Stall already in the accept cycle so the pipeline holds the instruction.
        busy = (state != S_IDLE) || (req && !flush && (is_mul || is_div));
    end

    // One multiply step, one divide step, and the sign-corrected results.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
`ifdef MULDIV_FAST_MUL_EN
        mul_next = {32'd0, operand} * {32'd0, acc[31:0]};
`else
        mul_next = {mul_sum, acc[31:1]};
`endif
        mul_res = neg_res ? (~mul_next + 64'd1) : mul_next;

        // 34 bits: with unsigned divisors the shifted remainder can reach 33 bits.
        div_trial = {1'b0, acc[63:32], acc[31]} - {2'b00, operand};
        div_next  = div_trial[33] ? {acc[62:0], 1'b0}
                                  : {div_trial[31:0], acc[30:0], 1'b1};

        if (div_zero) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = dividend;
        end else begin
            quo_fix = neg_res ? (~acc[31:0]  + 32'd1) : acc[31:0];
            rem_fix = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
        end
    end

    // Operand latch, iteration datapath, HI/LO and the done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            count    <= '0;
            acc      <= 64'd0;
            operand  <= 32'd0;
            dividend <= 32'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= mul_wr || div_wr;

            if (start) begin
                count    <= '0;
                operand  <= is_div ? mag_b : mag_a;
                acc      <= {32'd0, is_div ? mag_a : mag_b};
                neg_res  <= is_signed && (a[31] ^ b[31]);
                neg_rem  <= is_signed && a[31];
                div_zero <= (b == 32'd0);
                dividend <= a;
            end else if (state == S_MUL) begin
                acc   <= mul_next;
                count <= count + 1'b1;
            end else if (state == S_DIV) begin
                acc   <= div_next;
                count <= count + 1'b1;
            end

            if (mul_wr) begin
                hi <= mul_res[63:32];
                lo <= mul_res[31:0];
            end
            if (div_wr) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
            if (mthi_wr) hi <= a;
            if (mtlo_wr) lo <= a;
        end
    end

endmodule
